payment_sequencer: RTL and testbench
====================================

Name: payment_sequencer

Overview:
- Transaction controller placed downstream of the payment-method menu FSM.
- Takes a one-cycle "cash selected" or "card selected" strobe plus the product price, then runs one complete sale:
  - Cash: accumulates coin credit, compares it against the price and hands back change coin by coin through a hopper handshake.
  - Card: issues an authorization request and waits for approve or deny.
- Issues a single vend pulse per successful sale and reports done or error back to the menu logic.

Parameters:
- CREDIT_W, 8, width of the price, coin value, credit and change datapath.
- CHG_UNIT, 1, value of one change coin; each hopper handshake returns CHG_UNIT.
- TIMEOUT_CYC, 255, idle cycles allowed before a cash or card transaction aborts (used only with PAY_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- sel_cash  in  1  one-cycle strobe: cash payment chosen.
- sel_card  in  1  one-cycle strobe: card payment chosen.
- price  in  CREDIT_W  product price, sampled on the accepted select strobe.
- coin_valid  in  1  one-cycle strobe: a coin was inserted.
- coin_value  in  CREDIT_W  value of the inserted coin, qualified by coin_valid.
- cancel  in  1  user cancel request.
- card_ok  in  1  card approved (pulse).
- card_deny  in  1  card declined (pulse).
- chg_ack  in  1  hopper has ejected one change coin.
- busy  out  1  high while any transaction is active.
- credit  out  CREDIT_W  current accumulated cash credit.
- card_req  out  1  held high in CARD_WAIT.
- vend  out  1  one-cycle dispense pulse.
- chg_req  out  1  request to the hopper for one change coin.
- done  out  1  one-cycle pulse at the end of a successful transaction.
- error  out  1  one-cycle pulse on deny or timeout.

Behaviour:
- Reset:
  - State returns to IDLE.
  - All outputs are 0 and credit is 0.
  - The latched price and the change register are cleared.
  - A reset during any state abandons the transaction with no refund and no vend.
- State flow: IDLE, CASH_ACC, CARD_WAIT, VEND, CHANGE, DONE, FAIL.
- IDLE:
  - sel_cash latches price and moves to CASH_ACC.
  - sel_card latches price and moves to CARD_WAIT.
  - If both strobes arrive in the same cycle, sel_cash wins.
  - Coins, cancel and acks are ignored in IDLE.
- CASH_ACC:
  - On coin_valid, credit <= credit + coin_value, saturating at 2^CREDIT_W-1.
  - Once credit >= price (checked on registered credit, the cycle after the add), move to VEND and set change = credit - price.
  - cancel moves to CHANGE with change = credit, i.e. a full refund with no vend.
  - If cancel and coin_valid arrive in the same cycle, cancel wins and that coin is not credited.
  - A price of 0 reaches VEND on the first cycle in CASH_ACC.
- CARD_WAIT:
  - card_req stays high.
  - card_ok moves to VEND with change = 0.
  - card_deny or cancel moves to FAIL.
  - If card_ok and card_deny arrive together, deny wins.
- VEND:
  - vend is high for exactly one cycle.
  - Next state is CHANGE if change != 0, otherwise DONE.
- CHANGE:
  - chg_req stays high until chg_ack is sampled.
  - On each ack, change <= change - CHG_UNIT.
  - If change < CHG_UNIT, change is forced to 0 and the remainder is kept as machine profit.
  - chg_req drops in the cycle after the ack that brings change to 0.
  - The block then moves to DONE, or to IDLE if the change phase was a cancel refund; a refund pulses neither done nor error.
  - cancel is ignored in this state.
- DONE:
  - done pulses for one cycle.
  - credit clears and the block returns to IDLE.
- FAIL:
  - error pulses for one cycle and the block returns to IDLE.
  - FAIL is entered only from the card path or on timeout.
  - A cash timeout with credit > 0 routes through the refund CHANGE path first, then pulses error.
- Latencies:
  - Select strobe to busy high: 1 cycle.
  - Final coin to vend: 2 cycles.
- busy is high in every state except IDLE.

Optional Feature:
- Macro: PAY_TIMEOUT_EN.
- Defined:
  - An idle counter runs in CASH_ACC and CARD_WAIT; it is reset by coin_valid and by entering either state.
  - On reaching TIMEOUT_CYC, CARD_WAIT goes to FAIL, and CASH_ACC refunds the credit via CHANGE and then pulses error.
- Not defined:
  - No counter logic is built.
  - The block waits indefinitely for coins or a card response.

Decomposition:
- Package payment_pkg holds:
  - the state enum (3-bit encoding);
  - the CREDIT_W default;
  - a refund-flag constant.
- Sub-module pay_timer:
  - a loadable idle-timeout counter with clear and expire outputs;
  - instantiated only under PAY_TIMEOUT_EN.

Test Plan:
- Exact cash: price=10, sel_cash, coins 5,5 -> vend 2 cycles after the second coin, no chg_req, done pulse, credit returns to 0.
- Overpay: price=7, coin 10 -> vend, then chg_req with three acks (CHG_UNIT=1), done after the third ack; an ack held low keeps chg_req high.
- Cash cancel: price=20, coin 5, then cancel together with coin 5 -> no vend, 5 chg_req/ack cycles, no done, no error, back to IDLE.
- Card: sel_card, card_ok after 10 cycles -> vend, done; a second run with card_ok and card_deny together -> error, no vend.
- Saturation and reset: CREDIT_W=8, price=255, coins 200,100 -> credit=255 and vend; reset asserted mid-CHANGE -> all outputs 0 immediately, IDLE.
- With PAY_TIMEOUT_EN and TIMEOUT_CYC=16: cash with credit 3 and no further coins -> refund of 3 coins then error; card with no response -> error at cycle 16.

Source files
------------

// File: rtl/payment_pkg.sv
// rtl/payment_pkg.sv - shared state encoding and constants for the payment sequencer
package payment_pkg;

    localparam int CREDIT_W_DEF = 8;

    // Marks a change phase as a cancel/timeout refund rather than sale change
    localparam logic REFUND_FLAG = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CASH_ACC  = 3'd1,
        S_CARD_WAIT = 3'd2,
        S_VEND      = 3'd3,
        S_CHANGE    = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } pay_state_t;

endpackage

// File: rtl/pay_timer.sv
// rtl/pay_timer.sv - idle-timeout counter, expires after TIMEOUT_CYC running cycles since clear
module pay_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);
    localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_count;

    // Count running cycles; clear restarts the idle window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is suppressed in a cycle that also restarts the window
    assign o_expire = i_run && !i_clear && (r_count == LAST);

endmodule

// File: rtl/payment_sequencer.sv
// rtl/payment_sequencer.sv - cash/card sale sequencer; idle timeout built only with PAY_TIMEOUT_EN
module payment_sequencer
    import payment_pkg::*;
#(
    parameter int CREDIT_W    = CREDIT_W_DEF,
    parameter int CHG_UNIT    = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sel_cash,
    input  logic                sel_card,
    input  logic [CREDIT_W-1:0] price,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                cancel,
    input  logic                card_ok,
    input  logic                card_deny,
    input  logic                chg_ack,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic                card_req,
    output logic                vend,
    output logic                chg_req,
    output logic                done,
    output logic                error
);
    localparam logic [CREDIT_W-1:0] CHG_STEP   = CREDIT_W'(CHG_UNIT);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    pay_state_t          r_state;
    pay_state_t          w_next;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_price;
    logic [CREDIT_W-1:0] r_change;
    logic                r_refund;
    logic                r_to_fail;

    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_credit_add;
    logic [CREDIT_W-1:0] w_change_dec;
    logic                w_load;
    logic                w_add_coin;
    logic                w_clr_credit;
    logic                w_set_sale_chg;
    logic                w_set_refund;
    logic                w_refund_fail;
    logic                w_clr_change;
    logic                w_dec_change;
    logic                w_expire;

    assign w_sum        = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_credit_add = w_sum[CREDIT_W] ? CREDIT_MAX : w_sum[CREDIT_W-1:0];
    // A remainder smaller than one coin is kept by the machine
    assign w_change_dec = (r_change >= CHG_STEP) ? (r_change - CHG_STEP) : '0;
    assign credit       = r_credit;

`ifdef PAY_TIMEOUT_EN
    logic w_tmr_clear;
    logic w_tmr_run;

    assign w_tmr_clear = (r_state == S_IDLE) || coin_valid;
    assign w_tmr_run   = (r_state == S_CASH_ACC) || (r_state == S_CARD_WAIT);

    pay_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_tmr_clear),
        .i_run    (w_tmr_run),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, datapath controls and Moore outputs
    always_comb begin
        w_next         = r_state;
        w_load         = 1'b0;
        w_add_coin     = 1'b0;
        w_clr_credit   = 1'b0;
        w_set_sale_chg = 1'b0;
        w_set_refund   = 1'b0;
        w_refund_fail  = 1'b0;
        w_clr_change   = 1'b0;
        w_dec_change   = 1'b0;
        busy           = (r_state != S_IDLE);
        card_req       = 1'b0;
        vend           = 1'b0;
        chg_req        = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sel_cash) begin
                    w_load = 1'b1;
                    w_next = S_CASH_ACC;
                end else if (sel_card) begin
                    w_load = 1'b1;
                    w_next = S_CARD_WAIT;
                end
            end
            S_CASH_ACC: begin
                if (cancel) begin
                    w_set_refund = 1'b1;
                    w_next       = S_CHANGE;
                end else if (w_expire) begin
                    w_set_refund  = 1'b1;
                    w_refund_fail = 1'b1;
                    w_next        = S_CHANGE;
                end else if (r_credit >= r_price) begin
                    w_set_sale_chg = 1'b1;
                    w_next         = S_VEND;
                end else if (coin_valid) begin
                    w_add_coin = 1'b1;
                end
            end
            S_CARD_WAIT: begin
                card_req = 1'b1;
                if (card_deny || cancel || w_expire) begin
                    w_next = S_FAIL;
                end else if (card_ok) begin
                    w_clr_change = 1'b1;
                    w_next       = S_VEND;
                end
            end
            S_VEND: begin
                vend   = 1'b1;
                w_next = (r_change != '0) ? S_CHANGE : S_DONE;
            end
            S_CHANGE: begin
                chg_req      = (r_change != '0);
                w_dec_change = chg_ack && (r_change != '0);
                if ((r_change == '0) || (chg_ack && (w_change_dec == '0))) begin
                    if (r_to_fail) begin
                        w_next = S_FAIL;
                    end else if (r_refund == REFUND_FLAG) begin
                        w_clr_credit = 1'b1;
                        w_next       = S_IDLE;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_clr_credit = 1'b1;
                w_next       = S_IDLE;
            end
            S_FAIL: begin
                error        = 1'b1;
                w_clr_credit = 1'b1;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Price latch, credit accumulator and change register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_price   <= '0;
            r_credit  <= '0;
            r_change  <= '0;
            r_refund  <= 1'b0;
            r_to_fail <= 1'b0;
        end else begin
            if (w_load) begin
                r_price   <= price;
                r_credit  <= '0;
                r_change  <= '0;
                r_refund  <= 1'b0;
                r_to_fail <= 1'b0;
            end
            if (w_add_coin) begin
                r_credit <= w_credit_add;
            end
            if (w_clr_credit) begin
                r_credit <= '0;
            end
            if (w_set_sale_chg) begin
                r_change <= r_credit - r_price;
            end
            if (w_set_refund) begin
                r_change  <= r_credit;
                r_refund  <= REFUND_FLAG;
                r_to_fail <= w_refund_fail;
            end
            if (w_clr_change) begin
                r_change <= '0;
            end
            if (w_dec_change) begin
                r_change <= w_change_dec;
            end
        end
    end

endmodule

// File: tb/tb_payment_sequencer.sv
// tb/tb_payment_sequencer.sv - self-checking bench for payment_sequencer, timeout cases under PAY_TIMEOUT_EN
module tb_payment_sequencer;
    localparam int CW  = 8;
    localparam int TO  = 16;
    localparam int MAXC = (1 << CW) - 1;
`ifdef PAY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          sel_cash, sel_card, coin_valid, cancel, card_ok, card_deny, chg_ack;
    logic [CW-1:0] price, coin_value;
    logic          busy, card_req, vend, chg_req, done, error;
    logic [CW-1:0] credit;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    payment_sequencer #(.CREDIT_W(CW), .CHG_UNIT(1), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .sel_cash(sel_cash), .sel_card(sel_card), .price(price),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel), .card_ok(card_ok),
        .card_deny(card_deny), .chg_ack(chg_ack), .busy(busy), .credit(credit), .card_req(card_req),
        .vend(vend), .chg_req(chg_req), .done(done), .error(error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: one sale described by phase, credit, price and change owed
    localparam int M_IDLE = 0, M_CASH = 1, M_CARD = 2, M_VEND = 3, M_CHG = 4, M_DONE = 5, M_FAIL = 6;
    int   m_st, m_credit, m_price, m_change, m_idle, m_nc;
    bit   m_refund, m_tofail;
    logic m_exp;

    assign m_nc  = (m_change >= 1) ? m_change - 1 : 0;
    assign m_exp = TO_EN && (m_idle == TO - 1) && !coin_valid;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st <= M_IDLE; m_credit <= 0; m_price <= 0; m_change <= 0;
            m_idle <= 0; m_refund <= 1'b0; m_tofail <= 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (sel_cash || sel_card) begin
                    m_price <= int'(price); m_credit <= 0; m_idle <= 0;
                    m_refund <= 1'b0; m_tofail <= 1'b0;
                    m_st <= sel_cash ? M_CASH : M_CARD;
                end
                M_CASH: if (cancel || m_exp) begin
                    m_change <= m_credit; m_refund <= 1'b1; m_tofail <= !cancel; m_st <= M_CHG;
                end else if (m_credit >= m_price) begin
                    m_change <= m_credit - m_price; m_st <= M_VEND;
                end else if (coin_valid) begin
                    m_credit <= (m_credit + int'(coin_value) > MAXC) ? MAXC : m_credit + int'(coin_value);
                    m_idle <= 0;
                end else begin
                    m_idle <= m_idle + 1;
                end
                M_CARD: if (card_deny || cancel || m_exp) begin
                    m_st <= M_FAIL;
                end else if (card_ok) begin
                    m_change <= 0; m_st <= M_VEND;
                end else begin
                    m_idle <= coin_valid ? 0 : m_idle + 1;
                end
                M_VEND: m_st <= (m_change != 0) ? M_CHG : M_DONE;
                M_CHG: begin
                    if (chg_ack && m_change != 0) m_change <= m_nc;
                    if (m_change == 0 || (chg_ack && m_nc == 0)) begin
                        if (m_tofail) m_st <= M_FAIL;
                        else if (m_refund) begin m_st <= M_IDLE; m_credit <= 0; end
                        else m_st <= M_DONE;
                    end
                end
                default: begin m_st <= M_IDLE; m_credit <= 0; end
            endcase
        end
    end

    // Per-cycle compare and event bookkeeping
    int   cnt_vend = 0, cnt_done = 0, cnt_err = 0, cnt_ack = 0;
    int   vend_cyc = 0, err_cyc = 0, busy_cyc = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        check("outs", {18'd0, busy, credit, card_req, vend, chg_req, done, error},
              {18'd0, m_st != M_IDLE, m_credit[CW-1:0], m_st == M_CARD, m_st == M_VEND,
               (m_st == M_CHG) && (m_change != 0), m_st == M_DONE, m_st == M_FAIL});
        if (vend) begin cnt_vend++; vend_cyc = cyc; end
        if (done) cnt_done++;
        if (error) begin cnt_err++; err_cyc = cyc; end
        if (chg_req && chg_ack) cnt_ack++;
        if (busy && !busy_prev) busy_cyc = cyc;
        busy_prev = busy;
    end

    int b_vend, b_done, b_err, b_ack, coin_cyc;

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic snap(); b_vend = cnt_vend; b_done = cnt_done; b_err = cnt_err; b_ack = cnt_ack; endtask
    task automatic start_cash(input int p); price = CW'(p); sel_cash = 1'b1; tick(); sel_cash = 1'b0; endtask
    task automatic start_card(); sel_card = 1'b1; tick(); sel_card = 1'b0; endtask
    task automatic coin(input int v);
        coin_valid = 1'b1; coin_value = CW'(v); coin_cyc = cyc; tick(); coin_valid = 1'b0;
    endtask
    task automatic wait_chg(input string name, input int max);
        int n = 0;
        while (!chg_req && n < max) begin tick(); n++; end
        check(name, {31'd0, chg_req}, 32'd1);
    endtask
    task automatic serve_change(input string name, input int max);
        int n = 0;
        while (busy && n < max) begin
            if (chg_req) begin chg_ack = 1'b1; tick(); chg_ack = 1'b0; end
            tick(); n += 2;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask
    task automatic expect_events(input string name, input int v, input int d, input int e, input int a);
        check({name, "_vend"}, cnt_vend - b_vend, v);
        check({name, "_done"}, cnt_done - b_done, d);
        check({name, "_err"},  cnt_err - b_err, e);
        check({name, "_acks"}, cnt_ack - b_ack, a);
    endtask

    initial begin
        int s;
        reset = 1'b1; sel_cash = 0; sel_card = 0; coin_valid = 0; cancel = 0;
        card_ok = 0; card_deny = 0; chg_ack = 0; price = '0; coin_value = '0;
        repeat (3) tick();
        check("reset_outs", {18'd0, busy, credit, card_req, vend, chg_req, done, error}, 32'd0);
        reset = 1'b0;
        tick();

        // Idle ignores coins, cancel and acks
        coin_valid = 1'b1; coin_value = 8'd9; cancel = 1'b1; chg_ack = 1'b1; tick();
        coin_valid = 1'b0; cancel = 1'b0; chg_ack = 1'b0; tick();
        check("idle_ignore_busy", {31'd0, busy}, 32'd0);
        check("idle_ignore_credit", {24'd0, credit}, 32'd0);

        // Exact cash
        snap(); price = 8'd10; sel_cash = 1'b1;
        check("pre_sel_busy", {31'd0, busy}, 32'd0);
        tick(); sel_cash = 1'b0;
        check("sel_busy_lat1", {31'd0, busy}, 32'd1);
        coin(5); coin(5);
        serve_change("exact_end", 40);
        check("exact_vend_lat", vend_cyc - coin_cyc, 32'd2);
        check("exact_credit_clr", {24'd0, credit}, 32'd0);
        expect_events("exact", 1, 1, 0, 0);

        // Overpay with a held-off ack
        snap(); start_cash(7); coin(10);
        wait_chg("ovr_chg_req", 10);
        check("ovr_credit", {24'd0, credit}, 32'd10);
        repeat (3) tick();
        check("ovr_ack_hold", {31'd0, chg_req}, 32'd1);
        serve_change("ovr_end", 40);
        expect_events("ovr", 1, 1, 0, 3);

        // Cash cancel, cancel beats the same-cycle coin
        snap(); start_cash(20); coin(5);
        cancel = 1'b1; coin_valid = 1'b1; coin_value = 8'd5; tick();
        cancel = 1'b0; coin_valid = 1'b0;
        check("cancel_credit", {24'd0, credit}, 32'd5);
        serve_change("cancel_end", 60);
        expect_events("cancel", 0, 0, 0, 5);

        // Card approve after ten cycles
        snap(); start_card(); repeat (10) tick();
        check("card_req_held", {31'd0, card_req}, 32'd1);
        card_ok = 1'b1; tick(); card_ok = 1'b0;
        serve_change("card_ok_end", 20);
        expect_events("card_ok", 1, 1, 0, 0);

        // Card approve and deny together: deny wins
        snap(); start_card(); repeat (2) tick();
        card_ok = 1'b1; card_deny = 1'b1; tick(); card_ok = 1'b0; card_deny = 1'b0;
        serve_change("card_both_end", 20);
        expect_events("card_both", 0, 0, 1, 0);

        // Saturating credit at the top price
        snap(); start_cash(255); coin(200); coin(100);
        check("sat_credit", {24'd0, credit}, 32'd255);
        serve_change("sat_end", 20);
        expect_events("sat", 1, 1, 0, 0);

        // Price zero vends straight away
        snap(); s = cyc; start_cash(0);
        serve_change("zero_end", 20);
        check("zero_vend_lat", vend_cyc - s, 32'd2);
        expect_events("zero", 1, 1, 0, 0);

        // Both strobes: cash wins, no card request
        snap(); price = 8'd3; sel_cash = 1'b1; sel_card = 1'b1; tick();
        sel_cash = 1'b0; sel_card = 1'b0;
        check("both_card_req", {31'd0, card_req}, 32'd0);
        coin(3);
        serve_change("both_end", 20);
        expect_events("both", 1, 1, 0, 0);

        // Reset in the middle of change payout
        snap(); start_cash(5); coin(9);
        wait_chg("rst_chg_req", 10);
        chg_ack = 1'b1; tick(); chg_ack = 1'b0; tick();
        #2 reset = 1'b1; #1;
        check("rst_mid_outs", {18'd0, busy, credit, card_req, vend, chg_req, done, error}, 32'd0);
        tick(); reset = 1'b0; tick();
        check("rst_mid_idle", {31'd0, busy}, 32'd0);
        expect_events("rst_mid", 1, 0, 0, 1);

`ifdef PAY_TIMEOUT_EN
        // Cash timeout refunds the credit then reports error
        snap(); start_cash(10); coin(3);
        wait_chg("to_cash_chg", 40);
        serve_change("to_cash_end", 40);
        expect_events("to_cash", 0, 0, 1, 3);

        // Card timeout with no response
        snap(); start_card();
        serve_change("to_card_end", 60);
        check("to_card_lat", err_cyc - busy_cyc, TO);
        expect_events("to_card", 0, 0, 1, 0);
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
